// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor core and its instruction sequencer:
// opcode encodings, instruction field positions and the sequencer state type.
package proc_pkg;

    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int X_HI  = 12;
    localparam int X_LO  = 10;
    localparam int Y_HI  = 9;
    localparam int Y_LO  = 7;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        IMM,
        WAIT,
        ADV,
        HALTED,
        ERROR
    } seq_state_t;

    function automatic logic [2:0] opcode(input logic [15:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write port for the loader, two asynchronous read ports
// so the current word and the following (immediate) word are both available.
module prog_ram #(
    parameter int AW = 4,
    parameter int W  = 16
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr0,
    output logic [W-1:0]  rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction supplier for the multicycle core: steps a PC through program RAM,
// pulses Run with each opcode, supplies mvi immediates and waits (with watchdog) for Done.
module prog_sequencer
    import proc_pkg::*;
#(
    parameter int AW      = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [W-1:0]  LdData,
    input  logic          Done,
    output logic [W-1:0]  DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [AW-1:0] PC
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    seq_state_t     state, state_nxt;
    logic [AW-1:0]  pc_nxt;
    logic [AW-1:0]  pc_plus1;
    logic [WDW-1:0] wdog, wdog_nxt, wdog_inc;
    logic           mvi, mvi_nxt;
    logic [W-1:0]   word_pc, word_pc1;
    logic [2:0]     op;
    logic           busy;

    assign pc_plus1 = PC + AW'(1);
    assign wdog_inc = wdog + WDW'(1);
    assign op       = opcode(word_pc);

    prog_ram #(
        .AW(AW),
        .W (W)
    ) u_ram (
        .clock (Clock),
        .we    (LdEn && !busy),
        .waddr (LdAddr),
        .wdata (LdData),
        .raddr0(PC),
        .rdata0(word_pc),
        .raddr1(pc_plus1),
        .rdata1(word_pc1)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            PC    <= '0;
            wdog  <= '0;
            mvi   <= 1'b0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
            wdog  <= wdog_nxt;
            mvi   <= mvi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        wdog_nxt  = wdog;
        mvi_nxt   = mvi;
        case (state)
            IDLE, HALTED, ERROR: begin
                if (Start) begin
                    pc_nxt    = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                wdog_nxt = '0;
                if (op == OP_HALT) begin
                    state_nxt = HALTED;
                end else begin
                    mvi_nxt   = (op == OP_MVI);
                    state_nxt = (op == OP_MVI) ? IMM : WAIT;
                end
            end
            IMM: begin
                state_nxt = Done ? ADV : WAIT;
            end
            WAIT: begin
                if (Done) begin
                    state_nxt = ADV;
                end else begin
                    wdog_nxt = wdog_inc;
                    if (wdog_inc == WDW'(TIMEOUT)) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ADV: begin
                pc_nxt    = mvi ? PC + AW'(2) : pc_plus1;
                state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the state register directly, so Run falls with the async Reset.
    always_comb begin
        DIN    = '0;
        Run    = 1'b0;
        busy   = 1'b0;
        Halted = 1'b0;
        Error  = 1'b0;
        case (state)
            FETCH: begin
                DIN  = word_pc;
                Run  = (op != OP_HALT);
                busy = 1'b1;
            end
            IMM: begin
                DIN  = word_pc1;
                busy = 1'b1;
            end
            WAIT: begin
                DIN  = word_pc;
                busy = 1'b1;
            end
            ADV:     busy   = 1'b1;
            HALTED:  Halted = 1'b1;
            ERROR:   Error  = 1'b1;
            default: ;
        endcase
    end

    assign Busy = busy;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: constant vector table, hand-written corner
// sequences, and random programs checked against an instruction-level reference model.
module tb_prog_sequencer;

    localparam int TO = 15;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        LdEn;
    logic [3:0]  LdAddr;
    logic [15:0] LdData;
    logic        Done;
    logic [15:0] DIN;
    logic        Run;
    logic        Busy;
    logic        Halted;
    logic        Error;
    logic [3:0]  PC;

    prog_sequencer #(
        .AW     (4),
        .W      (16),
        .TIMEOUT(TO)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .LdEn  (LdEn),
        .LdAddr(LdAddr),
        .LdData(LdData),
        .Done  (Done),
        .DIN   (DIN),
        .Run   (Run),
        .Busy  (Busy),
        .Halted(Halted),
        .Error (Error),
        .PC    (PC)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    logic [15:0] prog [16];
    int          delays [64];

    logic [3:0]  got_pc [$];
    logic [15:0] got_din [$];
    logic [15:0] got_imm [$];
    logic [2:0]  got_flags;
    logic [3:0]  got_fpc;

    logic [3:0]  exp_pc [$];
    logic [15:0] exp_din [$];
    logic [15:0] exp_imm [$];

    typedef struct {
        logic [15:0] w0, w1, w2;
        int          d;
        int          runs;
        logic [2:0]  flags;   // {Busy, Halted, Error} at end
        logic [3:0]  pc;
        logic [15:0] imm;     // DIN one cycle after the first Run
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            LdEn   = 1'b1;
            LdAddr = 4'(i);
            LdData = prog[i];
            tick();
        end
        LdEn = 1'b0;
    endtask

    // Instruction-level model: walk the program, one event per issued instruction.
    task automatic model(input int max_runs, output logic [2:0] flags, output logic [3:0] fpc);
        int          pc, n, d, lim;
        logic [15:0] w;
        logic        is_mvi;
        exp_pc.delete();
        exp_din.delete();
        exp_imm.delete();
        pc = 0;
        n  = 0;
        while (1) begin
            w = prog[pc];
            if (w[15:13] == 3'b111) begin
                flags = 3'b010; fpc = 4'(pc); return;
            end
            if (n == max_runs) begin
                flags = 3'b100; fpc = 4'(pc); return;
            end
            is_mvi = (w[15:13] == 3'b001);
            exp_pc.push_back(4'(pc));
            exp_din.push_back(w);
            exp_imm.push_back(is_mvi ? prog[(pc + 1) % 16] : w);
            d   = delays[n];
            n++;
            // WAIT tolerates TO cycles; an mvi also spends one IMM cycle first
            lim = is_mvi ? TO + 1 : TO;
            if (d < 1 || d > lim) begin
                flags = 3'b001; fpc = 4'(pc); return;
            end
            pc = (pc + (is_mvi ? 2 : 1)) % 16;
        end
    endtask

    task automatic run_prog(input int max_runs, input bit hold, input bit ld0, input logic [15:0] ld0_data);
        int since, runs;
        bit prev_run, finished;
        got_pc.delete();
        got_din.delete();
        got_imm.delete();
        got_flags = 3'b000;
        got_fpc   = 4'h0;
        if (ld0) begin
            LdEn = 1'b1; LdAddr = 4'h0; LdData = ld0_data;
        end
        Start = 1'b1;
        tick();
        LdEn = 1'b0;
        if (!hold) Start = 1'b0;
        since    = 1000;
        runs     = 0;
        prev_run = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (Run) begin
                check("run_gap", 32'(prev_run), 0);
                runs++;
                if (runs > max_runs) begin
                    got_flags = {Busy, Halted, Error};
                    got_fpc   = PC;
                    finished  = 1'b1;
                end else begin
                    got_pc.push_back(PC);
                    got_din.push_back(DIN);
                    since = 0;
                end
            end else begin
                since++;
            end
            if (!finished) begin
                if (since == 1) got_imm.push_back(DIN);
                if (Halted || Error) begin
                    got_flags = {Busy, Halted, Error};
                    got_fpc   = PC;
                    finished  = 1'b1;
                end else begin
                    Done     = (runs > 0 && since == delays[runs-1]);
                    prev_run = Run;
                    tick();
                end
            end
        end
        if (!finished) check("cycle_budget", 0, 1);
        Done  = 1'b0;
        Start = 1'b0;
    endtask

    task automatic verify(input string tag, input int max_runs);
        logic [2:0] ef;
        logic [3:0] ep;
        model(max_runs, ef, ep);
        check({tag, ".runs"}, got_pc.size(), exp_pc.size());
        check({tag, ".imms"}, got_imm.size(), exp_imm.size());
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
            check({tag, ".pc"}, got_pc[i], exp_pc[i]);
            check({tag, ".din"}, got_din[i], exp_din[i]);
            if (i < got_imm.size()) check({tag, ".imm"}, got_imm[i], exp_imm[i]);
        end
        check({tag, ".flags"}, got_flags, ef);
        check({tag, ".final_pc"}, got_fpc, ep);
    endtask

    task automatic fill_delays(input int lo, input int hi);
        for (int i = 0; i < 64; i++) delays[i] = $urandom_range(hi, lo);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] first_din [$];
        logic [2:0]  r3;
        int          r;

        vt[0] = '{16'h2000, 16'h0005, 16'hE000, 1,  1, 3'b010, 4'd2, 16'h0005};
        vt[1] = '{16'h4500, 16'hE000, 16'hE000, 3,  1, 3'b010, 4'd1, 16'h4500};
        vt[2] = '{16'h6500, 16'hE000, 16'hE000, 15, 1, 3'b010, 4'd1, 16'h6500};
        vt[3] = '{16'h6500, 16'hE000, 16'hE000, 16, 1, 3'b001, 4'd0, 16'h6500};
        vt[4] = '{16'h2400, 16'h1234, 16'hE000, 16, 1, 3'b010, 4'd2, 16'h1234};
        vt[5] = '{16'h2400, 16'h1234, 16'hE000, 17, 1, 3'b001, 4'd0, 16'h1234};
        vt[6] = '{16'h0880, 16'hE000, 16'hE000, 0,  1, 3'b001, 4'd0, 16'h0880};
        vt[7] = '{16'hE000, 16'h4500, 16'hE000, 2,  0, 3'b010, 4'd0, 16'h0000};
        vt[8] = '{16'h4500, 16'h6500, 16'hE000, 2,  2, 3'b010, 4'd2, 16'h4500};

        Reset = 1'b1; Start = 1'b0; LdEn = 1'b0; LdAddr = '0; LdData = '0; Done = 1'b0;
        tick();
        check("rst.din", DIN, 0);
        check("rst.run", Run, 0);
        check("rst.busy", Busy, 0);
        check("rst.halted", Halted, 0);
        check("rst.error", Error, 0);
        check("rst.pc", PC, 0);
        Reset = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = 0; i < 16; i++) prog[i] = 16'hE000;
            prog[0] = vt[v].w0; prog[1] = vt[v].w1; prog[2] = vt[v].w2;
            load_all();
            for (int i = 0; i < 64; i++) delays[i] = vt[v].d;
            run_prog(8, 1'b0, 1'b0, 16'h0);
            check($sformatf("vec%0d.runs", v), got_pc.size(), vt[v].runs);
            check($sformatf("vec%0d.flags", v), got_flags, vt[v].flags);
            check($sformatf("vec%0d.pc", v), got_fpc, vt[v].pc);
            if (vt[v].runs > 0) begin
                check($sformatf("vec%0d.imm", v), (got_imm.size() > 0) ? got_imm[0] : 16'hxxxx, vt[v].imm);
                check($sformatf("vec%0d.din", v), (got_din.size() > 0) ? got_din[0] : 16'hxxxx, vt[v].w0);
            end
        end

        // Watchdog timing and recovery by Start
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 16'hE000;
        prog[0] = 16'h4500;
        load_all();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("wd.run", Run, 1);
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            if (k == 5)      check("wd.wait_din", DIN, 16'h4500);
            if (k == TO)     check("wd.err_early", {Busy, Error}, 2'b10);
            if (k == TO + 1) check("wd.err_set", {Busy, Error}, 2'b01);
        end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("wd.sticky", Error, 1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("wd.clear", {Error, Run, PC}, {1'b0, 1'b1, 4'h0});

        // Async reset in FETCH and WAIT; load attempt while busy is dropped
        do_reset();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("rstf.run_before", Run, 1);
        Reset = 1'b1;
        #1;
        check("rstf.run", Run, 0);
        check("rstf.busy", Busy, 0);
        tick();
        Reset = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("rstw.busy_before", Busy, 1);
        LdEn = 1'b1; LdAddr = 4'h1; LdData = 16'h4500;
        tick();
        LdEn = 1'b0;
        check("rstw.din", DIN, 16'h4500);
        Reset = 1'b1;
        #1;
        check("rstw.run_busy", {Run, Busy}, 2'b00);
        check("rstw.pc", PC, 0);
        check("rstw.din0", DIN, 0);
        tick();
        Reset = 1'b0;
        prog[0] = 16'h6500;
        fill_delays(1, 4);
        run_prog(8, 1'b0, 1'b1, 16'h6500);
        verify("ldstart", 8);

        // mvi in the last slot wraps for its immediate and its next PC
        do_reset();
        prog[0] = 16'h0ABC;
        for (int i = 1; i < 15; i++) prog[i] = 16'h4500;
        prog[15] = 16'h2000;
        load_all();
        fill_delays(1, 4);
        run_prog(17, 1'b0, 1'b0, 16'h0);
        verify("wrap", 17);

        // Rerun from HALTED with Start held high
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 16'hE000;
        prog[0] = 16'h2000; prog[1] = 16'h0005; prog[2] = 16'h4500;
        load_all();
        fill_delays(1, 5);
        run_prog(8, 1'b0, 1'b0, 16'h0);
        verify("rerun1", 8);
        first_din = got_din;
        run_prog(8, 1'b1, 1'b0, 16'h0);
        verify("rerun2", 8);
        check("rerun.len", got_din.size(), first_din.size());
        for (int i = 0; i < first_din.size() && i < got_din.size(); i++)
            check("rerun.trace", got_din[i], first_din[i]);

        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(7, 0);
                case (r)
                    0:       r3 = 3'b000;
                    1, 2:    r3 = 3'b001;
                    3, 4:    r3 = 3'b010;
                    5, 6:    r3 = 3'b011;
                    default: r3 = 3'b111;
                endcase
                prog[i] = {r3, 13'($urandom)};
            end
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(19, 0);
                case (r)
                    16:      delays[i] = 0;
                    17:      delays[i] = TO;
                    18:      delays[i] = TO + 1;
                    19:      delays[i] = TO + 2;
                    default: delays[i] = $urandom_range(6, 1);
                endcase
            end
            load_all();
            run_prog(30, 1'b0, 1'b0, 16'h0);
            verify($sformatf("rand%0d", it), 30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
